// File: rtl/turn_position_ctrl.sv
// Turn and position sequencer for a board game of 2 to 4 players.
// Tracks positions, laps and the active player, and declares a winner.
module turn_position_ctrl #(
  parameter int BOARD_LEN = 24,
  parameter int WIN_LAPS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] n_in,
  input  logic       mv_valid,
  input  logic       mv_hit,
  output logic       mv_ready,
  output logic [1:0] T,
  output logic [1:0] N,
  output logic [4:0] p1_cnt,
  output logic [4:0] p2_cnt,
  output logic [4:0] p3_cnt,
  output logic [4:0] p4_cnt,
  output logic       turn_chg,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam logic [4:0] LAST = 5'(BOARD_LEN - 1);
  localparam logic [2:0] WIN  = 3'(WIN_LAPS);

  logic [1:0] state;
  logic [4:0] pos  [4];
  logic [2:0] laps [4];
  logic       accept;
  logic [1:0] last_t;
  logic [2:0] lap_next;

  assign mv_ready  = (state == PLAY);
  assign game_over = (state == OVER);
  assign accept    = mv_valid & mv_ready;

  // Last active index is N+1; N never exceeds 2, so this fits in 2 bits.
  assign last_t   = N + 2'd1;
  assign lap_next = laps[T] + 3'd1;

  assign p1_cnt = pos[0];
  assign p2_cnt = pos[1];
  assign p3_cnt = pos[2];
  assign p4_cnt = pos[3];

  // Game state: start beats moves, moves only apply while playing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      T        <= 2'd0;
      N        <= 2'd0;
      turn_chg <= 1'b0;
      winner   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        pos[i]  <= 5'd0;
        laps[i] <= 3'd0;
      end
    end else begin
      turn_chg <= 1'b0;
      if (start) begin
        state  <= PLAY;
        T      <= 2'd0;
        N      <= (n_in == 2'd3) ? 2'd2 : n_in;
        winner <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          pos[i]  <= 5'd0;
          laps[i] <= 3'd0;
        end
      end else if (accept) begin
        if (mv_hit) begin
          if (pos[T] == LAST) begin
            pos[T]  <= 5'd0;
            laps[T] <= lap_next;
            if (lap_next == WIN) begin
              state  <= OVER;
              winner <= T;
            end
          end else begin
            pos[T] <= pos[T] + 5'd1;
          end
        end else begin
          T        <= (T == last_t) ? 2'd0 : T + 2'd1;
          turn_chg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_position_ctrl.sv
// Bench for turn_position_ctrl: directed game scenarios checked every
// cycle against an arithmetic game model, plus hand-computed anchors.
module tb_turn_position_ctrl;

  localparam int BL = 24;
  localparam int WL = 1;

  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic [1:0] n_in = 0;
  logic       mv_valid = 0;
  logic       mv_hit = 0;
  logic       mv_ready;
  logic [1:0] T, N, winner;
  logic [4:0] p1, p2, p3, p4;
  logic       turn_chg, game_over;

  turn_position_ctrl #(.BOARD_LEN(BL), .WIN_LAPS(WL)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in),
    .mv_valid(mv_valid), .mv_hit(mv_hit), .mv_ready(mv_ready),
    .T(T), .N(N),
    .p1_cnt(p1), .p2_cnt(p2), .p3_cnt(p3), .p4_cnt(p4),
    .turn_chg(turn_chg), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model: phase 0 idle, 1 playing, 2 finished.
  int m_phase, m_t, m_n, m_win, m_turn;
  int m_pos [4];
  int m_laps [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_pos[i] = 0;
      m_laps[i] = 0;
    end
    m_t = 0;
    m_win = 0;
  endtask

  task automatic model_apply(input bit r, input bit s, input int n,
                             input bit v, input bit h);
    int p;
    m_turn = 0;
    if (r) begin
      model_clear();
      m_n = 0;
      m_phase = 0;
    end else if (s) begin
      model_clear();
      m_n = (n > 2) ? 2 : n;
      m_phase = 1;
    end else if (v && m_phase == 1) begin
      if (h) begin
        p = m_t;
        m_pos[p] = (m_pos[p] + 1) % BL;
        if (m_pos[p] == 0) begin
          m_laps[p]++;
          if (m_laps[p] == WL) begin
            m_phase = 2;
            m_win = p;
          end
        end
      end else begin
        m_t = (m_t + 1) % (m_n + 2);
        m_turn = 1;
      end
    end
  endtask

  // One clock with the given inputs; model advances at the same edge.
  task automatic step(input bit r, input bit s, input int n,
                      input bit v, input bit h);
    rst = r;
    start = s;
    n_in = 2'(n);
    mv_valid = v;
    mv_hit = h;
    @(posedge clk);
    model_apply(r, s, n, v, h);
    #1;
    rst = 0;
    start = 0;
    mv_valid = 0;
    mv_hit = 0;
  endtask

  task automatic hits(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 1, 1);
  endtask

  task automatic misses(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 1, 0);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mv_ready", int'(mv_ready), int'(m_phase == 1));
      chk("game_over", int'(game_over), int'(m_phase == 2));
      chk("T", int'(T), m_t);
      chk("N", int'(N), m_n);
      chk("p1_cnt", int'(p1), m_pos[0]);
      chk("p2_cnt", int'(p2), m_pos[1]);
      chk("p3_cnt", int'(p3), m_pos[2]);
      chk("p4_cnt", int'(p4), m_pos[3]);
      chk("turn_chg", int'(turn_chg), m_turn);
      chk("winner", int'(winner), m_win);
    end
  end

  int pulses;

  initial begin
    // 1: two players, three misses
    step(1, 0, 0, 0, 0);
    chk_en = 1;
    chk("reset_ready", int'(mv_ready), 0);
    step(0, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      pulses += int'(turn_chg);
    end
    chk("t1_T", int'(T), 1);
    chk("t1_pulses", pulses, 3);
    step(0, 0, 0, 0, 0);
    chk("t1_pulse_end", int'(turn_chg), 0);

    // 2: four players, player 3 moves five squares
    step(0, 1, 2, 0, 0);
    misses(2);
    hits(5);
    chk("t2_T", int'(T), 2);
    chk("t2_p3", int'(p3), 5);
    chk("t2_p1", int'(p1), 0);

    // 3: three players wrap; illegal code becomes four players
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t3_T_a", int'(T), 1);
    step(0, 0, 0, 1, 0);
    chk("t3_T_b", int'(T), 2);
    step(0, 0, 0, 1, 0);
    chk("t3_T_c", int'(T), 0);
    step(0, 1, 3, 0, 0);
    chk("t3_N", int'(N), 2);
    misses(3);
    chk("t3_T_d", int'(T), 3);
    misses(1);
    chk("t3_T_e", int'(T), 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("t3_hit_no_valid", int'(p1), 1);

    // 4: player 1 completes a lap and wins
    step(0, 1, 0, 0, 0);
    hits(23);
    chk("t4_p1_23", int'(p1), 23);
    chk("t4_not_over", int'(game_over), 0);
    hits(1);
    chk("t4_p1_wrap", int'(p1), 0);
    chk("t4_over", int'(game_over), 1);
    chk("t4_winner", int'(winner), 0);
    chk("t4_ready", int'(mv_ready), 0);
    hits(2);
    misses(2);
    chk("t4_frozen_T", int'(T), 0);
    chk("t4_frozen_p1", int'(p1), 0);

    // 4b: player 2 wins, restarting from OVER
    step(0, 1, 0, 0, 0);
    misses(1);
    hits(BL);
    chk("t4b_winner", int'(winner), 1);
    chk("t4b_over", int'(game_over), 1);

    // 5: start wins against a simultaneous move
    step(0, 1, 0, 0, 0);
    hits(7);
    chk("t5_p1_7", int'(p1), 7);
    step(0, 1, 0, 1, 1);
    chk("t5_p1", int'(p1), 0);
    chk("t5_ready", int'(mv_ready), 1);

    // 6: reset mid-game, moves ignored until start
    step(0, 1, 0, 0, 0);
    misses(1);
    hits(9);
    chk("t6_p2_9", int'(p2), 9);
    step(1, 0, 0, 1, 1);
    chk("t6_p2", int'(p2), 0);
    chk("t6_T", int'(T), 0);
    hits(3);
    misses(2);
    chk("t6_idle_p1", int'(p1), 0);
    chk("t6_idle_ready", int'(mv_ready), 0);
    step(1, 1, 2, 0, 0);
    chk("t6_rst_beats_start", int'(mv_ready), 0);
    step(0, 0, 0, 0, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
